defloater: RTL

Sequential inverse of the team's integer/decimal-digit to 16-bit float encoder. Accepts a 16-bit float word (sign, 8-bit biased exponent, 7-bit mantissa with an implicit leading 1), denormalises it with one shift per cycle, and returns a signed integer part plus one truncated decimal fraction digit. It sits on the readback path of the arithmetic datapath. It uses a Start/Busy/Done handshake.

---
 rtl/floater_pkg.sv | 33 +++
 rtl/defloater_if.sv | 24 ++
 rtl/defloater_digit.sv | 14 +
 rtl/defloater.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/floater_pkg.sv
// Shared types and constants for the 16-bit float encoder/decoder family.
package floater_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned SIGN_BIT       = 15;
    localparam int unsigned EXP_W          = 8;
    localparam int unsigned MANT_W         = 7;
    localparam int unsigned EXP_LSB        = MANT_W;
    localparam int unsigned EXP_BIAS       = 127;
    localparam int unsigned MAX_RSHIFT     = 9;
    localparam int unsigned OVF_EXP_OFFSET = 7;

    // Q8.8 working register, 8-bit integer/fraction outputs, shift counter
    localparam int unsigned FIX_W   = 16;
    localparam int unsigned FRAC_W  = 8;
    localparam int unsigned INT_W   = 8;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        DIGIT = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp16_t;

endpackage

// File: rtl/defloater_if.sv
// Request/result bundle between a readback client and the defloater.
interface defloater_if;
    import floater_pkg::*;

    logic             start;
    fp16_t            data;
    logic             busy;
    logic             done;
    logic             sign;
    logic [INT_W-1:0] a;
    logic [INT_W-1:0] b;
    logic             overflow;

    modport master (
        output start, data,
        input  busy, done, sign, a, b, overflow
    );

    modport slave (
        input  start, data,
        output busy, done, sign, a, b, overflow
    );

endinterface

// File: rtl/defloater_digit.sv
// Maps an 8-bit binary fraction to its truncated leading decimal digit.
module defloater_digit
    import floater_pkg::*;
(
    input  logic [FRAC_W-1:0]  frac_i,
    output logic [DIGIT_W-1:0] digit_c
);

    localparam int unsigned PROD_W = FRAC_W + 4;

    // f*10 as (f<<3)+(f<<1); the top nibble of the 12-bit product is the digit
    assign digit_c = DIGIT_W'(((PROD_W'(frac_i) << 3) + (PROD_W'(frac_i) << 1)) >> FRAC_W);

endmodule

// File: rtl/defloater.sv
// Sequential float-to-integer/decimal-digit converter, one alignment shift per cycle.
module defloater
    import floater_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    defloater_if.slave  bus
);

    localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(EXP_BIAS);
    localparam logic [EXP_W-1:0] OVF_E  = EXP_W'(EXP_BIAS + OVF_EXP_OFFSET);
    localparam logic [EXP_W-1:0] CAP_E  = EXP_W'(MAX_RSHIFT);
    localparam logic [INT_W-1:0] POS_SAT = INT_W'(127);
    localparam logic [INT_W-1:0] NEG_SAT = INT_W'(8'h81);
    localparam logic [INT_W-1:0] SAT_DIGIT = INT_W'(9);

    state_e             state_q, state_d;
    logic [FIX_W-1:0]   f_q, f_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               left_q, left_d;
    logic               neg_q, neg_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sign_q, sign_d;
    logic [INT_W-1:0]   a_q, a_d;
    logic [INT_W-1:0]   b_q, b_d;
    logic               ovf_q, ovf_d;

    logic [EXP_W-1:0]   exp_c;
    logic [EXP_W-1:0]   rdiff_c;
    logic [FIX_W-1:0]   f_load_c;
    logic [CNT_W-1:0]   n_load_c;
    logic               left_load_c;
    logic               ovf_load_c;
    logic [INT_W-1:0]   m_c;
    logic [DIGIT_W-1:0] digit_c;

    defloater_digit u_digit (
        .frac_i  (f_q[FRAC_W-1:0]),
        .digit_c (digit_c)
    );

    // Decode of the incoming word into the initial Q8.8 value and shift plan
    always_comb begin
        exp_c       = bus.data.exp;
        rdiff_c     = BIAS_E - exp_c;
        f_load_c    = FIX_W'({1'b1, bus.data.mant, 1'b0});
        n_load_c    = '0;
        left_load_c = 1'b0;
        ovf_load_c  = 1'b0;
        if (exp_c == '0) begin
            f_load_c = '0;
        end else if (exp_c >= OVF_E) begin
            f_load_c   = '0;
            ovf_load_c = 1'b1;
        end else if (exp_c > BIAS_E) begin
            n_load_c    = CNT_W'(exp_c - BIAS_E);
            left_load_c = 1'b1;
        end else if (exp_c < BIAS_E) begin
            n_load_c = (rdiff_c > CAP_E) ? CNT_W'(MAX_RSHIFT) : CNT_W'(rdiff_c);
        end
    end

    assign m_c = f_q[FIX_W-1:FRAC_W];

    // Next-state and datapath; ALIGN spends one extra cycle once n has reached zero
    always_comb begin
        state_d    = state_q;
        f_d        = f_q;
        n_d        = n_q;
        left_d     = left_q;
        neg_d      = neg_q;
        ovf_pend_d = ovf_pend_q;
        sign_d     = sign_q;
        a_d        = a_q;
        b_d        = b_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_d      = bus.data.sign;
                    f_d        = f_load_c;
                    n_d        = n_load_c;
                    left_d     = left_load_c;
                    ovf_pend_d = ovf_load_c;
                    state_d    = ALIGN;
                end
            end
            ALIGN: begin
                if (n_q == '0) begin
                    state_d = DIGIT;
                end else begin
                    f_d = left_q ? (f_q << 1) : (f_q >> 1);
                    n_d = n_q - CNT_W'(1);
                end
            end
            DIGIT: begin
                sign_d = neg_q;
                if (ovf_pend_q) begin
                    a_d   = neg_q ? NEG_SAT : POS_SAT;
                    b_d   = SAT_DIGIT;
                    ovf_d = 1'b1;
                end else begin
                    a_d   = neg_q ? INT_W'(-m_c) : m_c;
                    b_d   = INT_W'(digit_c);
                    ovf_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            f_q        <= '0;
            n_q        <= '0;
            left_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sign_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_q        <= f_d;
            n_q        <= n_d;
            left_q     <= left_d;
            neg_q      <= neg_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sign_q     <= sign_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sign     = sign_q;
    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.overflow = ovf_q;

endmodule
